// File: rtl/wash_seq.sv
// Washing-machine program sequencer: wash, N rinses and spin with prescaled timing,
// drum reversal, pause and power-off abort. Optional buzzer via `WASH_SEQ_BUZZER_EN.
module wash_seq #(
  parameter int TICK_DIV = 50,
  parameter int TIME_W   = 6,
  parameter int WASH_T   = 20,
  parameter int RINSE_T  = 10,
  parameter int SPIN_T   = 8,
  parameter int RINSES   = 2,
  parameter int DIR_T    = 2,
  parameter int BUZZ_T   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power_on,
  input  logic              start,
  input  logic              i_stop,
  input  logic [1:0]        mode,
  output logic              led_wash,
  output logic              led_rinse,
  output logic              led_spin,
  output logic              led_done,
  output logic              led_stop,
  output logic              motor_fwd,
  output logic              motor_rev,
  output logic [TIME_W-1:0] remain,
  output logic [2:0]        rinse_no,
  output logic              buzzer
);

  localparam int PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW      = (DIR_T > 1) ? $clog2(DIR_T) : 1;
  localparam int QUICK_T = ((WASH_T / 2) < 1) ? 1 : (WASH_T / 2);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DIR_LAST   = DW'(DIR_T - 1);
  localparam logic [2:0]    STD_RINSES = 3'(RINSES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_RINSE = 3'd2,
    S_SPIN  = 3'd3,
    S_DONE  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  function automatic logic [2:0] rinse_count(input logic [1:0] m);
    case (m)
      2'b00:   rinse_count = STD_RINSES;
      2'b01:   rinse_count = 3'd1;
      2'b10:   rinse_count = STD_RINSES;
      default: rinse_count = 3'd0;
    endcase
  endfunction

  function automatic logic [TIME_W-1:0] phase_dur(input state_t ph, input logic [1:0] m);
    case (ph)
      S_WASH:  phase_dur = (m == 2'b01) ? TIME_W'(QUICK_T) : TIME_W'(WASH_T);
      S_RINSE: phase_dur = TIME_W'(RINSE_T);
      S_SPIN:  phase_dur = TIME_W'(SPIN_T);
      default: phase_dur = {TIME_W{1'b0}};
    endcase
  endfunction

  state_t            state_q, state_d, ret_q, ret_d, state_s, next_s, disp_s;
  logic [1:0]        mode_q, mode_d;
  logic [PW-1:0]     presc_q, presc_d, presc_s;
  logic [TIME_W-1:0] remain_q, remain_d, remain_s;
  logic [2:0]        rinse_q, rinse_d, rinse_s, rinse_sel_s, nr_s;
  logic [DW-1:0]     dir_cnt_q, dir_cnt_d, dir_cnt_s;
  logic              dir_rev_q, dir_rev_d, dir_rev_s;
  logic              resume_q, resume_d;
  logic              load_s, tick_s, run_dir_s;
  logic              led_wash_q, led_rinse_q, led_spin_q, led_done_q, led_stop_q;
  logic              led_wash_d, led_rinse_d, led_spin_d, led_done_d, led_stop_d;
  logic              motor_fwd_q, motor_rev_q, motor_fwd_d, motor_rev_d;
  logic [2:0]        rinse_no_q, rinse_no_d;

  // Next-state: the case yields either an in-phase update or a request to load a new phase.
  always_comb begin
    state_s     = state_q;
    ret_d       = ret_q;
    mode_d      = mode_q;
    presc_s     = presc_q;
    remain_s    = remain_q;
    rinse_s     = rinse_q;
    dir_cnt_s   = dir_cnt_q;
    dir_rev_s   = dir_rev_q;
    resume_d    = 1'b0;
    load_s      = 1'b0;
    next_s      = S_IDLE;
    rinse_sel_s = 3'd0;
    nr_s        = rinse_count(mode_q);
    tick_s      = (presc_q == PRESC_LAST);
    if (!power_on) begin
      state_s   = S_IDLE;
      ret_d     = S_IDLE;
      presc_s   = {PW{1'b0}};
      remain_s  = {TIME_W{1'b0}};
      rinse_s   = 3'd0;
      dir_cnt_s = {DW{1'b0}};
      dir_rev_s = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_s = {PW{1'b0}};
          if (start && !i_stop) begin
            mode_d = mode;
            load_s = 1'b1;
            case (mode)
              2'b10: begin
                if (STD_RINSES != 3'd0) begin
                  next_s      = S_RINSE;
                  rinse_sel_s = 3'd1;
                end else begin
                  next_s = S_SPIN;
                end
              end
              2'b11:   next_s = S_SPIN;
              default: next_s = S_WASH;
            endcase
          end else begin
            mode_d = mode_q;
          end
        end
        S_WASH, S_RINSE, S_SPIN: begin
          if (i_stop) begin
            // a tick landing here is dropped; the prescaler stays at its last count
            state_s = S_PAUSE;
            ret_d   = state_q;
          end else if (resume_q) begin
            presc_s = presc_q;
          end else if (!tick_s) begin
            presc_s = presc_q + PW'(1);
          end else if (remain_q > TIME_W'(1)) begin
            presc_s  = {PW{1'b0}};
            remain_s = remain_q - TIME_W'(1);
            if ((state_q != S_SPIN) && (dir_cnt_q == DIR_LAST)) begin
              dir_cnt_s = {DW{1'b0}};
              dir_rev_s = ~dir_rev_q;
            end else if (state_q != S_SPIN) begin
              dir_cnt_s = dir_cnt_q + DW'(1);
            end else begin
              dir_cnt_s = dir_cnt_q;
            end
          end else begin
            load_s = 1'b1;
            case (state_q)
              S_WASH: begin
                if (nr_s != 3'd0) begin
                  next_s      = S_RINSE;
                  rinse_sel_s = 3'd1;
                end else begin
                  next_s = S_SPIN;
                end
              end
              S_RINSE: begin
                if (rinse_q < nr_s) begin
                  next_s      = S_RINSE;
                  rinse_sel_s = rinse_q + 3'd1;
                end else begin
                  next_s = S_SPIN;
                end
              end
              default: next_s = S_DONE;
            endcase
          end
        end
        S_PAUSE: begin
          if (!i_stop) begin
            state_s  = ret_q;
            resume_d = 1'b1;
          end else begin
            state_s = S_PAUSE;
          end
        end
        S_DONE: begin
          if (!start) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_DONE;
          end
        end
        default: begin
          state_s  = S_IDLE;
          remain_s = {TIME_W{1'b0}};
          rinse_s  = 3'd0;
        end
      endcase
    end
    state_d   = load_s ? next_s : state_s;
    presc_d   = load_s ? {PW{1'b0}} : presc_s;
    remain_d  = load_s ? phase_dur(next_s, mode_d) : remain_s;
    rinse_d   = load_s ? rinse_sel_s : rinse_s;
    dir_cnt_d = load_s ? {DW{1'b0}} : dir_cnt_s;
    dir_rev_d = load_s ? 1'b0 : dir_rev_s;
  end

  // Output decode from next-state values so every output comes straight from a flop.
  always_comb begin
    disp_s      = (state_d == S_PAUSE) ? ret_d : state_d;
    run_dir_s   = (state_d == S_WASH) || (state_d == S_RINSE);
    led_wash_d  = (disp_s == S_WASH);
    led_rinse_d = (disp_s == S_RINSE);
    led_spin_d  = (disp_s == S_SPIN);
    led_done_d  = (state_d == S_DONE);
    led_stop_d  = (state_d == S_PAUSE);
    motor_fwd_d = (run_dir_s && !dir_rev_d) || (state_d == S_SPIN);
    motor_rev_d = run_dir_s && dir_rev_d;
    rinse_no_d  = (disp_s == S_RINSE) ? rinse_d : 3'd0;
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      mode_q    <= 2'b00;
      presc_q   <= {PW{1'b0}};
      remain_q  <= {TIME_W{1'b0}};
      rinse_q   <= 3'd0;
      dir_cnt_q <= {DW{1'b0}};
      dir_rev_q <= 1'b0;
      resume_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      remain_q  <= remain_d;
      rinse_q   <= rinse_d;
      dir_cnt_q <= dir_cnt_d;
      dir_rev_q <= dir_rev_d;
      resume_q  <= resume_d;
    end
  end

  // Registered panel and motor outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_wash_q  <= 1'b0;
      led_rinse_q <= 1'b0;
      led_spin_q  <= 1'b0;
      led_done_q  <= 1'b0;
      led_stop_q  <= 1'b0;
      motor_fwd_q <= 1'b0;
      motor_rev_q <= 1'b0;
      rinse_no_q  <= 3'd0;
    end else begin
      led_wash_q  <= led_wash_d;
      led_rinse_q <= led_rinse_d;
      led_spin_q  <= led_spin_d;
      led_done_q  <= led_done_d;
      led_stop_q  <= led_stop_d;
      motor_fwd_q <= motor_fwd_d;
      motor_rev_q <= motor_rev_d;
      rinse_no_q  <= rinse_no_d;
    end
  end

  assign led_wash  = led_wash_q;
  assign led_rinse = led_rinse_q;
  assign led_spin  = led_spin_q;
  assign led_done  = led_done_q;
  assign led_stop  = led_stop_q;
  assign motor_fwd = motor_fwd_q;
  assign motor_rev = motor_rev_q;
  assign remain    = remain_q;
  assign rinse_no  = rinse_no_q;

`ifdef WASH_SEQ_BUZZER_EN
  localparam int BUZZ_CYC = BUZZ_T * TICK_DIV;
  localparam int BW       = (BUZZ_CYC > 0) ? $clog2(BUZZ_CYC + 1) : 1;

  logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic          buzzer_q, buzzer_d;

  // Buzzer window counts down from DONE entry and collapses as soon as DONE is left.
  always_comb begin
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      buzz_cnt_d = BW'(BUZZ_CYC);
    end else if ((state_d == S_DONE) && (buzz_cnt_q != {BW{1'b0}})) begin
      buzz_cnt_d = buzz_cnt_q - BW'(1);
    end else begin
      buzz_cnt_d = {BW{1'b0}};
    end
    buzzer_d = (buzz_cnt_d != {BW{1'b0}});
  end

  // Buzzer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzz_cnt_q <= {BW{1'b0}};
      buzzer_q   <= 1'b0;
    end else begin
      buzz_cnt_q <= buzz_cnt_d;
      buzzer_q   <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;
`else
  assign buzzer = 1'b0;
`endif

endmodule
